// File: rtl/rv32i_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package rv32i_mem_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_D    = 2'd2
    } owner_e;

    localparam int WORD_ADDR_W          = 30;
    localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified memory.
interface rv32i_mem_arbiter_if #(
    parameter int CNT_W = 16
);
    import rv32i_mem_pkg::*;

    logic                   if_req;
    logic [31:0]            if_addr;
    logic                   if_gnt;
    logic                   if_rvalid;
    logic [31:0]            if_rdata;

    logic                   d_req;
    logic                   d_we;
    logic [31:0]            d_addr;
    logic [31:0]            d_wdata;
    logic [3:0]             d_wstrb;
    logic                   d_gnt;
    logic                   d_rvalid;
    logic [31:0]            d_rdata;

    logic                   mem_req;
    logic                   mem_we;
    logic [WORD_ADDR_W-1:0] mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_wstrb;
    logic [31:0]            mem_rdata;

    logic [CNT_W-1:0]       if_stall_cnt;

    // The arbiter is the slave of both requesters and drives the memory port.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_stall_cnt
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_stall_cnt
    );

endinterface

// File: rtl/rv32i_starve_ctr.sv
// Counts consecutive denied fetch cycles and flags when the fetch must win.
module rv32i_starve_ctr
    import rv32i_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req_i,
    input  logic if_gnt_i,
    output logic starve_o
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any grant or idle fetch restarts the count; it never runs past the limit.
    always_comb begin
        cnt_d = '0;
        if (if_req_i && !if_gnt_i) begin
            cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve_o = (cnt_q == LIMIT);

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Two-requester arbiter sharing one single-cycle-latency memory between fetch and load/store.
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int CNT_W        = 16
) (
    input logic               clk,
    input logic               rst,
    rv32i_mem_arbiter_if.slave bus
);

    logic             starve;
    logic             ifGnt;
    logic             dGnt;
    owner_e           owner_q;
    owner_e           owner_d;
    logic             storeAck_q;
    logic             storeAck_d;
    logic [CNT_W-1:0] stallCnt_q;
    logic [CNT_W-1:0] stallCnt_d;
    logic             ifValid;
    logic             dValid;
    logic             unusedAddrBits;

    rv32i_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .if_req_i (bus.if_req),
        .if_gnt_i (ifGnt),
        .starve_o (starve)
    );

    // Data normally wins; a starved fetch overrides it for exactly one cycle.
    always_comb begin
        ifGnt = 1'b0;
        dGnt  = 1'b0;
        if (!rst) begin
            if (bus.if_req && (!bus.d_req || starve)) begin
                ifGnt = 1'b1;
            end else if (bus.d_req) begin
                dGnt = 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_req   = ifGnt | dGnt;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = 4'h0;
        owner_d       = OWNER_NONE;
        storeAck_d    = 1'b0;
        if (dGnt) begin
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr[31:2];
            bus.mem_wdata = bus.d_wdata;
            bus.mem_wstrb = bus.d_we ? bus.d_wstrb : 4'h0;
            owner_d       = OWNER_D;
            storeAck_d    = bus.d_we;
        end else if (ifGnt) begin
            bus.mem_addr  = bus.if_addr[31:2];
            owner_d       = OWNER_IF;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (bus.if_req && !ifGnt && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWNER_NONE;
            storeAck_q <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            storeAck_q <= storeAck_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // Gating with rst drops a response whose grant happened just before reset.
    assign ifValid          = !rst && (owner_q == OWNER_IF);
    assign dValid           = !rst && (owner_q == OWNER_D);
    assign bus.if_gnt       = ifGnt;
    assign bus.d_gnt        = dGnt;
    assign bus.if_rvalid    = ifValid;
    assign bus.d_rvalid     = dValid;
    assign bus.if_rdata     = ifValid ? bus.mem_rdata : 32'h0;
    assign bus.d_rdata      = (dValid && !storeAck_q) ? bus.mem_rdata : 32'h0;
    assign bus.if_stall_cnt = stallCnt_q;
    assign unusedAddrBits   = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed scenario bench for the fetch/data memory arbiter with a small behavioural memory.
module tb_rv32i_mem_arbiter;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    logic [31:0] memArr [0:15];

    rv32i_mem_arbiter_if #(.CNT_W(4)) bus ();

    rv32i_mem_arbiter #(
        .STARVE_LIMIT(4),
        .CNT_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory answers one cycle after each strobe and applies byte-enabled writes.
    always @(posedge clk) begin
        if (bus.mem_req) begin
            bus.mem_rdata <= memArr[bus.mem_addr[3:0]];
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_wstrb[b]) memArr[bus.mem_addr[3:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one cycle of requests just after the rising edge and returns at the falling edge.
    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic dReq, input logic dWe, input logic [31:0] dAddr,
                                 input logic [31:0] dWdata, input logic [3:0] dWstrb);
        @(posedge clk);
        #1;
        bus.if_req  = ifReq;
        bus.if_addr = ifAddr;
        bus.d_req   = dReq;
        bus.d_we    = dWe;
        bus.d_addr  = dAddr;
        bus.d_wdata = dWdata;
        bus.d_wstrb = dWstrb;
        @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        bus.d_we   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h8;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h14;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++; if (bus.if_gnt !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_if_gnt: got %0h expected 0", bus.if_gnt); end
        compared++; if (bus.d_gnt !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_d_gnt: got %0h expected 0", bus.d_gnt); end
        compared++; if (bus.mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mem_req: got %0h expected 0", bus.mem_req); end
        compared++; if (bus.if_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_if_rvalid: got %0h expected 0", bus.if_rvalid); end
        compared++; if (bus.d_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_d_rvalid: got %0h expected 0", bus.d_rvalid); end
        compared++; if (bus.if_stall_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL rst_stall_cnt: got %0d expected 0", bus.if_stall_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.if_req = 1'b0;
        @(negedge clk);
        compared++; if (bus.d_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL first_cycle_gnt: got %0h expected 1", bus.d_gnt); end
        compared++; if (bus.mem_addr !== 30'd5) begin mismatched++; $display("[TB] FAIL first_cycle_addr: got %0h expected 5", bus.mem_addr); end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        compared++; if (bus.d_rvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL first_rvalid: got %0h expected 1", bus.d_rvalid); end
        compared++; if (bus.d_rdata !== 32'hA000_0005) begin mismatched++; $display("[TB] FAIL first_rdata: got %h expected a0000005", bus.d_rdata); end
    endtask

    task automatic test_fetch();
        doReset();
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        compared++; if (bus.if_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_gnt: got %0h expected 1", bus.if_gnt); end
        compared++; if (bus.d_gnt !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_d_gnt: got %0h expected 0", bus.d_gnt); end
        compared++; if (bus.mem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_mem_req: got %0h expected 1", bus.mem_req); end
        compared++; if (bus.mem_addr !== 30'd2) begin mismatched++; $display("[TB] FAIL fetch_mem_addr: got %0h expected 2", bus.mem_addr); end
        compared++; if ({bus.mem_we, bus.mem_wstrb} !== 5'h0) begin mismatched++; $display("[TB] FAIL fetch_we_strb: got %0h expected 0", {bus.mem_we, bus.mem_wstrb}); end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        compared++; if (bus.if_rvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_rvalid: got %0h expected 1", bus.if_rvalid); end
        compared++; if (bus.if_rdata !== 32'h0010_0073) begin mismatched++; $display("[TB] FAIL fetch_rdata: got %h expected 00100073", bus.if_rdata); end
        compared++; if (bus.d_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_d_rvalid: got %0h expected 0", bus.d_rvalid); end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        compared++; if (bus.if_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_rvalid_once: got %0h expected 0", bus.if_rvalid); end
    endtask

    task automatic test_collision();
        doReset();
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b1, 32'h0, 32'd15, 4'hF);
        compared++; if (bus.d_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL coll_d_gnt: got %0h expected 1", bus.d_gnt); end
        compared++; if (bus.if_gnt !== 1'b0) begin mismatched++; $display("[TB] FAIL coll_if_gnt: got %0h expected 0", bus.if_gnt); end
        compared++; if (bus.mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL coll_mem_we: got %0h expected 1", bus.mem_we); end
        compared++; if (bus.mem_wdata !== 32'd15) begin mismatched++; $display("[TB] FAIL coll_wdata: got %h expected 0000000f", bus.mem_wdata); end
        compared++; if (bus.mem_wstrb !== 4'hF) begin mismatched++; $display("[TB] FAIL coll_wstrb: got %0h expected f", bus.mem_wstrb); end
        compared++; if (bus.mem_addr !== 30'd0) begin mismatched++; $display("[TB] FAIL coll_addr: got %0h expected 0", bus.mem_addr); end
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        compared++; if (bus.d_rvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL coll_store_ack: got %0h expected 1", bus.d_rvalid); end
        compared++; if (bus.d_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL coll_store_rdata: got %h expected 00000000", bus.d_rdata); end
        compared++; if (bus.if_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL coll_if_gnt_next: got %0h expected 1", bus.if_gnt); end
        compared++; if (bus.mem_addr !== 30'd3) begin mismatched++; $display("[TB] FAIL coll_if_addr: got %0h expected 3", bus.mem_addr); end
        compared++; if (bus.if_stall_cnt !== 4'd1) begin mismatched++; $display("[TB] FAIL coll_stall_cnt: got %0d expected 1", bus.if_stall_cnt); end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        compared++; if (bus.if_rdata !== 32'hA000_0003) begin mismatched++; $display("[TB] FAIL coll_if_rdata: got %h expected a0000003", bus.if_rdata); end
    endtask

    task automatic test_starvation();
        logic       expIf;
        logic [3:0] expStall;
        doReset();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
            expIf    = (k % 5 == 0);
            expStall = 4'((k - 1) - ((k - 1) / 5));
            compared++; if (bus.if_gnt !== expIf) begin mismatched++; $display("[TB] FAIL starve_if_gnt c%0d: got %0h expected %0h", k, bus.if_gnt, expIf); end
            compared++; if (bus.d_gnt !== !expIf) begin mismatched++; $display("[TB] FAIL starve_d_gnt c%0d: got %0h expected %0h", k, bus.d_gnt, !expIf); end
            compared++; if (bus.if_stall_cnt !== expStall) begin mismatched++; $display("[TB] FAIL starve_stall c%0d: got %0d expected %0d", k, bus.if_stall_cnt, expStall); end
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        compared++; if (bus.if_stall_cnt !== 4'd8) begin mismatched++; $display("[TB] FAIL starve_stall_end: got %0d expected 8", bus.if_stall_cnt); end
    endtask

    task automatic test_back_to_back();
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        compared++; if (bus.d_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_c1_d_gnt: got %0h expected 1", bus.d_gnt); end
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        compared++; if (bus.if_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_c2_if_gnt: got %0h expected 1", bus.if_gnt); end
        compared++; if (bus.d_rvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_c2_d_rvalid: got %0h expected 1", bus.d_rvalid); end
        compared++; if (bus.d_rdata !== 32'h0000_000F) begin mismatched++; $display("[TB] FAIL b2b_c2_d_rdata: got %h expected 0000000f", bus.d_rdata); end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        compared++; if (bus.d_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_c3_d_gnt: got %0h expected 1", bus.d_gnt); end
        compared++; if (bus.if_rvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_c3_if_rvalid: got %0h expected 1", bus.if_rvalid); end
        compared++; if (bus.if_rdata !== 32'h0010_0073) begin mismatched++; $display("[TB] FAIL b2b_c3_if_rdata: got %h expected 00100073", bus.if_rdata); end
        compared++; if (bus.d_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_c3_d_rvalid: got %0h expected 0", bus.d_rvalid); end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        compared++; if (bus.d_rvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_c4_d_rvalid: got %0h expected 1", bus.d_rvalid); end
        compared++; if (bus.d_rdata !== 32'hA000_0005) begin mismatched++; $display("[TB] FAIL b2b_c4_d_rdata: got %h expected a0000005", bus.d_rdata); end
        compared++; if (bus.if_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_c4_if_rvalid: got %0h expected 0", bus.if_rvalid); end
    endtask

    task automatic test_reset_mid_txn();
        doReset();
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        compared++; if (bus.if_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_gnt: got %0h expected 1", bus.if_gnt); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h1C;
        bus.d_wdata = 32'h1234_5678;
        bus.d_wstrb = 4'hF;
        @(negedge clk);
        compared++; if (bus.if_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_if_rvalid: got %0h expected 0", bus.if_rvalid); end
        compared++; if (bus.if_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_if_rdata: got %h expected 00000000", bus.if_rdata); end
        compared++; if ({bus.if_gnt, bus.d_gnt, bus.mem_req, bus.d_rvalid} !== 4'h0) begin mismatched++; $display("[TB] FAIL midrst_ctrl: got %0h expected 0", {bus.if_gnt, bus.d_gnt, bus.mem_req, bus.d_rvalid}); end
        compared++; if ({bus.mem_we, bus.mem_wstrb, bus.mem_addr} !== 35'h0) begin mismatched++; $display("[TB] FAIL midrst_mem: got %0h expected 0", {bus.mem_we, bus.mem_wstrb, bus.mem_addr}); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        bus.d_we   = 1'b0;
        @(negedge clk);
        compared++; if (bus.if_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_after_rvalid: got %0h expected 0", bus.if_rvalid); end
        compared++; if (bus.if_stall_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL midrst_stall: got %0d expected 0", bus.if_stall_cnt); end
    endtask

    task automatic test_saturation();
        doReset();
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
            if (k == 17) begin
                compared++; if (bus.if_stall_cnt !== 4'd13) begin mismatched++; $display("[TB] FAIL sat_c17: got %0d expected 13", bus.if_stall_cnt); end
            end
            if (k == 20 || k == 25 || k == 30) begin
                compared++; if (bus.if_stall_cnt !== 4'd15) begin mismatched++; $display("[TB] FAIL sat_c%0d: got %0d expected 15", k, bus.if_stall_cnt); end
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        clk        = 1'b0;
        rst        = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0;
        bus.d_wdata   = 32'h0;
        bus.d_wstrb   = 4'h0;
        bus.mem_rdata = 32'h0;
        for (int i = 0; i < 16; i++) memArr[i] = 32'hA000_0000 + 32'(i);
        memArr[2] = 32'h0010_0073;

        test_reset();
        test_fetch();
        test_collision();
        test_starvation();
        test_back_to_back();
        test_reset_mid_txn();
        test_saturation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive cycles a pending fetch may be denied before it takes priority.
REQ-002 Parameter: CNT_W, default 16, width of the fetch-stall statistics counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request.
REQ-006 if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch data valid.
REQ-009 if_rdata  output  32  fetch data.
REQ-010 d_req  input  1  load/store request.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  32  data byte address; bits [1:0] ignored.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_wstrb  input  4  store byte enables.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  load data valid, or store acknowledge.
REQ-017 d_rdata  output  32  load data; 0 on store acknowledge.
REQ-018 mem_req  output  1  unified memory access strobe.
REQ-019 mem_we  output  1  memory write enable.
REQ-020 mem_addr  output  30  memory word address.
REQ-021 mem_wdata  output  32  memory write data.
REQ-022 mem_wstrb  output  4  memory byte enables; 0 on reads.
REQ-023 mem_rdata  input  32  memory read data, valid exactly one cycle after mem_req.
REQ-024 if_stall_cnt  output  CNT_W  saturating count of cycles with if_req high and if_gnt low.

Function
REQ-025 Grants SHALL be combinational from the current requests and registered state: at most one of if_gnt and d_gnt is high, and mem_req = if_gnt | d_gnt.
REQ-026 When granted, mem_addr/mem_we/mem_wdata/mem_wstrb SHALL come from the granted requester in the same cycle; for a fetch, mem_we = 0 and mem_wstrb = 0.
REQ-027 Default priority: data wins when both request.
REQ-028 Starvation: a counter SHALL increment on each cycle with if_req high and if_gnt low, and clear whenever if_gnt is high or if_req is low.
REQ-029 When the starvation counter equals STARVE_LIMIT, fetch wins over data in that cycle.
REQ-030 A requester that is not granted SHALL hold its request stable; the arbiter need not support withdrawal.
REQ-031 Owner register: on every grant, record the owner (IF or D) for the following cycle; record NONE if there is no grant.
REQ-032 Response latency: exactly 1 cycle after the grant, the recorded owner's rvalid is high for one cycle, with rdata = mem_rdata.
REQ-033 Back-to-back grants in consecutive cycles SHALL be supported at full throughput, one per cycle, interleaving owners with no bubble.
REQ-034 Store response: d_rvalid = 1 and d_rdata = 0 one cycle after the store grant.
REQ-035 if_stall_cnt SHALL saturate at 2^CNT_W - 1 and not wrap.

Reset
REQ-036 While rst = 1: if_gnt, d_gnt, mem_req, if_rvalid and d_rvalid are 0; the owner is NONE; the starvation counter and if_stall_cnt are 0.
REQ-037 A grant issued in the cycle before rst is asserted SHALL produce no rvalid: reset mid-transaction drops the pending response.
REQ-038 The first grant is possible in the first cycle with rst = 0.

Structure
REQ-039 Package rv32i_mem_pkg: owner encoding (NONE/IF/D), the word-address width constant (30), and the default STARVE_LIMIT.
REQ-040 One sub-module, rv32i_starve_ctr: the starvation counter with limit compare; everything else stays inline.

Verification
REQ-041 Fetch only: if_req=1, if_addr=0x8, with mem returning 0x00100073 -> if_gnt=1, mem_addr=2 in that cycle; if_rvalid=1 and if_rdata=0x00100073 in the next cycle.
REQ-042 Collision: d_req store with d_addr=0x0, d_wdata=15, d_wstrb=0xF, plus if_req in the same cycle -> d_gnt=1, mem_we=1, if_gnt=0; next cycle d_rvalid=1, d_rdata=0, and if_gnt=1 if d_req is low.
REQ-043 Starvation: d_req and if_req held high continuously with STARVE_LIMIT=4 -> d_gnt for 4 cycles, then if_gnt in cycle 5, then the pattern repeats; if_stall_cnt increments by 4 per period.
REQ-044 Pipelining: alternating grants D, IF, D over 3 cycles -> rvalid is routed D, IF, D over the next 3 cycles, with no bubbles and correct rdata per cycle.
REQ-045 Reset mid-transaction: fetch granted, then rst=1 in the next cycle -> if_rvalid=0; all outputs are 0 while rst=1.
REQ-046 Saturation: CNT_W=4 with fetch blocked for 20 cycles -> if_stall_cnt holds at 15.
